// File: rtl/multicycle_control_unit.sv
// ---------------------------------------------------------------------------
// multicycle_control_unit
//
// Multi-cycle control FSM for the TSC CPU. Each instruction is broken into
// IF / ID / EX / MEM / WB steps. One memory port and one ALU are shared
// across those steps, and this block drives the datapath muxes and enables
// that select between them. Memory accesses use a req/ready handshake.
//
// Ports:
//   clk, reset_n        system clock (rising edge), async active-low reset
//   opcode, func_code   instruction register fields, valid from ID onward
//   branch_taken        datapath branch-condition result, valid in EX
//   mem_ready           memory completes the current access this cycle
//   mem_read/mem_write  memory requests, held until mem_ready
//   i_or_d              memory address select: 0 = PC, 1 = ALU result
//   ir_write, pc_write  IR / PC load enables
//   pc_src              0 PC+1, 1 branch target, 2 jump target, 3 register
//   reg_write, reg_dst  register-file write enable, destination select
//                       (0 rt, 1 rd, 2 link $2)
//   alu_src, sign_ex    immediate operand select, immediate sign-extension
//   mem_to_reg          write-back data taken from memory
//   is_wwd              one-cycle output-port strobe
//   halted              processor stopped by HLT
//   num_inst            retired-instruction count, wraps modulo 2^CNT_W
//
// state | meaning
// ------+-----------------------------------------------------------------
// IF    | fetch word at PC; wait for mem_ready, then load IR and PC+1
// ID    | decode; jumps, WWD and undefined words finish here
// EX    | ALU step; branches finish here
// MEM   | data access for LWD / SWD; SWD finishes here
// WB    | register write-back
// HALT  | stopped until reset
// ---------------------------------------------------------------------------
module multicycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int FUNC_W   = 6,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNC_W-1:0]   func_code,
    input  logic                branch_taken,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic [1:0]          reg_dst,
    output logic                alu_src,
    output logic                sign_ex,
    output logic                mem_to_reg,
    output logic                is_wwd,
    output logic                halted,
    output logic [CNT_W-1:0]    num_inst
);

    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_BGZ   = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BLZ   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_ADI   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_LHI   = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(15);

    localparam logic [FUNC_W-1:0] FN_ALU_MAX = FUNC_W'(7);
    localparam logic [FUNC_W-1:0] FN_JPR     = FUNC_W'(25);
    localparam logic [FUNC_W-1:0] FN_JRL     = FUNC_W'(26);
    localparam logic [FUNC_W-1:0] FN_WWD     = FUNC_W'(28);
    localparam logic [FUNC_W-1:0] FN_HLT     = FUNC_W'(29);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t state, state_next;
    logic   retire;

    logic dec_rtype, dec_ralu, dec_ialu, dec_branch, dec_lwd, dec_swd;
    logic dec_jmp, dec_jal, dec_jpr, dec_jrl, dec_wwd, dec_hlt, dec_undef;

    assign dec_rtype  = (opcode == OP_RTYPE);
    assign dec_ralu   = dec_rtype && (func_code <= FN_ALU_MAX);
    assign dec_jpr    = dec_rtype && (func_code == FN_JPR);
    assign dec_jrl    = dec_rtype && (func_code == FN_JRL);
    assign dec_wwd    = dec_rtype && (func_code == FN_WWD);
    assign dec_hlt    = dec_rtype && (func_code == FN_HLT);
    assign dec_branch = (opcode == OP_BNE) || (opcode == OP_BEQ) ||
                        (opcode == OP_BGZ) || (opcode == OP_BLZ);
    assign dec_ialu   = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
    assign dec_lwd    = (opcode == OP_LWD);
    assign dec_swd    = (opcode == OP_SWD);
    assign dec_jmp    = (opcode == OP_JMP);
    assign dec_jal    = (opcode == OP_JAL);
    // Anything not recognised (opcodes 11..14, unused R-type functions)
    // retires from ID as a NOP.
    assign dec_undef  = !(dec_ralu || dec_jpr || dec_jrl || dec_wwd || dec_hlt ||
                          dec_branch || dec_ialu || dec_lwd || dec_swd ||
                          dec_jmp || dec_jal);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IF;
            num_inst <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                num_inst <= num_inst + CNT_W'(1);
            end
        end
    end

    // Next state; retire marks the edge that leaves an instruction's last step.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            S_IF: begin
                if (mem_ready) begin
                    state_next = S_ID;
                end
            end
            S_ID: begin
                if (dec_hlt) begin
                    state_next = S_HALT;
                end else if (dec_jmp || dec_jal || dec_jpr || dec_jrl ||
                             dec_wwd || dec_undef) begin
                    state_next = S_IF;
                    retire     = 1'b1;
                end else begin
                    state_next = S_EX;
                end
            end
            S_EX: begin
                if (dec_branch) begin
                    state_next = S_IF;
                    retire     = 1'b1;
                end else if (dec_lwd || dec_swd) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (dec_swd) begin
                        state_next = S_IF;
                        retire     = 1'b1;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                state_next = S_IF;
                retire     = 1'b1;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IF;
        endcase
    end

    // Outputs are forced low while reset_n is low so an outstanding request
    // drops immediately, without waiting for a clock edge.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'd0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        alu_src    = 1'b0;
        sign_ex    = 1'b0;
        mem_to_reg = 1'b0;
        is_wwd     = 1'b0;
        halted     = 1'b0;
        if (reset_n) begin
            case (state)
                S_IF: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_ID: begin
                    if (dec_jmp || dec_jal) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd2;
                    end
                    if (dec_jpr || dec_jrl) begin
                        pc_write = 1'b1;
                        pc_src   = 2'd3;
                    end
                    if (dec_jal || dec_jrl) begin
                        reg_write = 1'b1;
                        reg_dst   = 2'd2;
                    end
                    is_wwd = dec_wwd;
                end
                S_EX: begin
                    if (dec_branch) begin
                        pc_write = branch_taken;
                        pc_src   = 2'd1;
                    end
                    alu_src = dec_ialu || dec_lwd || dec_swd;
                    sign_ex = dec_branch || dec_lwd || dec_swd || (opcode == OP_ADI);
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = dec_lwd;
                    mem_write = dec_swd;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = dec_ralu ? 2'd1 : 2'd0;
                    mem_to_reg = dec_lwd;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam int C_RALU = 0, C_IALU = 1, C_LWD = 2, C_SWD = 3, C_BR = 4,
                   C_JMP = 5, C_JAL = 6, C_JPR = 7, C_JRL = 8, C_WWD = 9,
                   C_HLT = 10, C_NOP = 11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  opcode;
    logic [5:0]  func_code;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_read, mem_write, i_or_d, ir_write, pc_write;
    logic [1:0]  pc_src, reg_dst;
    logic        reg_write, alu_src, sign_ex, mem_to_reg, is_wwd, halted;
    logic [15:0] num_inst;

    logic        reset_n2;
    logic [3:0]  opcode2;
    logic [5:0]  func_code2;
    logic        mem_read2, mem_write2, i_or_d2, ir_write2, pc_write2;
    logic [1:0]  pc_src2, reg_dst2;
    logic        reg_write2, alu_src2, sign_ex2, mem_to_reg2, is_wwd2, halted2;
    logic [1:0]  num_inst2;

    int n_asserts = 0;
    int n_fail    = 0;
    int exp_cnt   = 0;
    int acc, acc_cyc;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func_code(func_code),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src),
        .sign_ex(sign_ex), .mem_to_reg(mem_to_reg), .is_wwd(is_wwd),
        .halted(halted), .num_inst(num_inst)
    );

    multicycle_control_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n2), .opcode(opcode2), .func_code(func_code2),
        .branch_taken(1'b0), .mem_ready(1'b1),
        .mem_read(mem_read2), .mem_write(mem_write2), .i_or_d(i_or_d2),
        .ir_write(ir_write2), .pc_write(pc_write2), .pc_src(pc_src2),
        .reg_write(reg_write2), .reg_dst(reg_dst2), .alu_src(alu_src2),
        .sign_ex(sign_ex2), .mem_to_reg(mem_to_reg2), .is_wwd(is_wwd2),
        .halted(halted2), .num_inst(num_inst2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int classify(input logic [3:0] op, input logic [5:0] fn);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return C_BR;
            4'd4, 4'd5, 4'd6:       return C_IALU;
            4'd7:  return C_LWD;
            4'd8:  return C_SWD;
            4'd9:  return C_JMP;
            4'd10: return C_JAL;
            4'd15: begin
                if (fn < 6'd8)   return C_RALU;
                if (fn == 6'd25) return C_JPR;
                if (fn == 6'd26) return C_JRL;
                if (fn == 6'd28) return C_WWD;
                if (fn == 6'd29) return C_HLT;
                return C_NOP;
            end
            default: return C_NOP;
        endcase
    endfunction

    // Answers the current request after the programmed number of wait cycles;
    // with no request outstanding mem_ready is random and must be ignored.
    task automatic set_ready(input int wif, input int wmem);
        int w;
        if (mem_read || mem_write) begin
            w = (acc == 0) ? wif : wmem;
            mem_ready = (acc_cyc >= w);
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic post_ready();
        if (mem_read || mem_write) begin
            if (mem_ready) begin
                acc++;
                acc_cyc = 0;
            end else begin
                acc_cyc++;
            end
        end
    endtask

    // Entered shortly after a negedge while the DUT is in IF.
    task automatic run_inst(input logic [3:0] op, input logic [5:0] fn, input logic taken,
                            input int wif, input int wmem);
        int cls, total, mw;
        int n_rd, n_wr, n_iod, n_ir, n_pcw, n_rw, n_m2r, n_wwd, n_alu, n_sx, n_hlt;
        int last_src, last_dst, moved;
        int e_pcw, e_src, e_rw, e_dst;
        cls = classify(op, fn);
        opcode = op; func_code = fn; branch_taken = taken;
        mw = (cls == C_LWD || cls == C_SWD) ? wmem + 1 : 0;
        case (cls)
            C_RALU, C_IALU, C_SWD: total = 4;
            C_LWD:  total = 5;
            C_BR:   total = 3;
            default: total = 2;
        endcase
        total += wif + ((mw > 0) ? wmem : 0);
        e_pcw = 1; e_src = 0; e_rw = 0; e_dst = 0;
        if (cls == C_JMP || cls == C_JAL) begin e_pcw = 2; e_src = 2; end
        if (cls == C_JPR || cls == C_JRL) begin e_pcw = 2; e_src = 3; end
        if (cls == C_BR && taken) begin e_pcw = 2; e_src = 1; end
        if (cls == C_RALU) begin e_rw = 1; e_dst = 1; end
        if (cls == C_IALU || cls == C_LWD) e_rw = 1;
        if (cls == C_JAL || cls == C_JRL) begin e_rw = 1; e_dst = 2; end
        {n_rd, n_wr, n_iod, n_ir, n_pcw, n_rw, n_m2r, n_wwd, n_alu, n_sx, n_hlt} = '0;
        last_src = 0; last_dst = 0; moved = 0;
        acc = 0; acc_cyc = 0;
        for (int c = 0; c < total; c++) begin
            set_ready(wif, wmem);
            #1;
            chk("rd_wr_exclusive", 32'(mem_read & mem_write), 0);
            n_rd += int'(mem_read);  n_wr += int'(mem_write); n_iod += int'(i_or_d);
            n_ir += int'(ir_write);  n_m2r += int'(mem_to_reg); n_wwd += int'(is_wwd);
            n_alu += int'(alu_src);  n_sx += int'(sign_ex); n_hlt += int'(halted);
            if (pc_write)  begin n_pcw++; last_src = int'(pc_src); end
            if (reg_write) begin n_rw++;  last_dst = int'(reg_dst); end
            if (int'(num_inst) != exp_cnt) moved = 1;
            post_ready();
            @(negedge clk);
        end
        chk("mem_read_cycles", n_rd, wif + 1 + ((cls == C_LWD) ? mw : 0));
        chk("mem_write_cycles", n_wr, (cls == C_SWD) ? mw : 0);
        chk("i_or_d_cycles", n_iod, mw);
        chk("ir_write_cycles", n_ir, 1);
        chk("pc_write_cycles", n_pcw, e_pcw);
        chk("pc_src_last", last_src, e_src);
        chk("reg_write_cycles", n_rw, e_rw);
        if (e_rw != 0) chk("reg_dst", last_dst, e_dst);
        chk("mem_to_reg_cycles", n_m2r, (cls == C_LWD) ? 1 : 0);
        chk("is_wwd_cycles", n_wwd, (cls == C_WWD) ? 1 : 0);
        chk("alu_src_cycles", n_alu, (cls == C_IALU || cls == C_LWD || cls == C_SWD) ? 1 : 0);
        chk("sign_ex_cycles", n_sx,
            (cls == C_BR || cls == C_LWD || cls == C_SWD || op == 4'd4) ? 1 : 0);
        chk("halted_cycles", n_hlt, 0);
        chk("count_stable_mid", moved, 0);
        exp_cnt = (exp_cnt + 1) % 65536;
        #1;
        chk("refetch_read", 32'(mem_read), 1);
        chk("refetch_i_or_d", 32'(i_or_d), 0);
        chk("num_inst", 32'(num_inst), exp_cnt);
    endtask

    task automatic run_hlt(input int wif);
        int n_hlt;
        opcode = 4'd15; func_code = 6'd29; branch_taken = 1'b0;
        acc = 0; acc_cyc = 0; n_hlt = 0;
        for (int c = 0; c < wif + 2; c++) begin
            set_ready(wif, 0);
            #1;
            n_hlt += int'(halted);
            post_ready();
            @(negedge clk);
        end
        chk("halt_not_early", n_hlt, 0);
        for (int c = 0; c < 20; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("halt_halted", 32'(halted), 1);
            chk("halt_no_read", 32'(mem_read), 0);
            chk("halt_no_enables", 32'({mem_write, ir_write, pc_write, reg_write, is_wwd}), 0);
            chk("halt_count", 32'(num_inst), exp_cnt);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        #1;
        reset_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rst_num_inst", 32'(num_inst), 0);
        chk("rst_outputs", 32'({mem_read, mem_write, ir_write, pc_write, reg_write,
                                is_wwd, halted, i_or_d}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("post_rst_read", 32'(mem_read), 1);
        chk("post_rst_others", 32'({mem_write, ir_write, pc_write, reg_write, halted}), 0);
    endtask

    task automatic rand_inst();
        logic [3:0] op;
        logic [5:0] fn;
        op = 4'($urandom_range(0, 15));
        fn = 6'($urandom_range(0, 63));
        if (op == 4'd15 && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 3))
                0: fn = 6'd25;
                1: fn = 6'd26;
                2: fn = 6'd28;
                default: fn = 6'($urandom_range(0, 7));
            endcase
        end
        if (classify(op, fn) == C_HLT) fn = 6'd28;
        run_inst(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[5];
        int c2, wwd_pulses, back_to_back;
        logic prev_wwd;
        seq[0] = 1; seq[1] = 2; seq[2] = 3; seq[3] = 0; seq[4] = 1;
        reset_n = 1'b0; reset_n2 = 1'b0;
        opcode = '0; func_code = '0; branch_taken = 1'b0; mem_ready = 1'b1;
        opcode2 = 4'd15; func_code2 = 6'd28;
        #12;
        do_reset();

        run_inst(4'd15, 6'd0, 1'b0, 0, 0);    // ADD
        run_inst(4'd7, 6'd5, 1'b0, 2, 3);     // LWD, 10 cycles
        run_inst(4'd1, 6'd0, 1'b1, 0, 0);     // BEQ taken
        run_inst(4'd1, 6'd0, 1'b0, 0, 0);     // BEQ not taken
        run_inst(4'd10, 6'd0, 1'b0, 0, 0);    // JAL
        run_inst(4'd8, 6'd1, 1'b0, 1, 2);     // SWD
        run_inst(4'd12, 6'd0, 1'b0, 0, 0);    // undefined opcode
        for (int i = 0; i < 60; i++) rand_inst();
        run_hlt(1);

        do_reset();
        run_inst(4'd4, 6'd3, 1'b0, 0, 0);
        run_inst(4'd15, 6'd25, 1'b0, 1, 0);
        run_inst(4'd15, 6'd28, 1'b0, 0, 0);
        run_hlt(2);

        do_reset();
        run_inst(4'd9, 6'd0, 1'b0, 0, 0);
        run_inst(4'd5, 6'd0, 1'b0, 0, 0);
        mem_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("mid_wait_read", 32'(mem_read), 1);
        reset_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("async_drop_read", 32'(mem_read), 0);
        chk("async_num_inst", 32'(num_inst), 0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("restart_read", 32'(mem_read), 1);
        chk("restart_i_or_d", 32'(i_or_d), 0);
        run_inst(4'd15, 6'd2, 1'b0, 1, 0);

        @(negedge clk);
        reset_n2 = 1'b1;
        wwd_pulses = 0; back_to_back = 0; prev_wwd = 1'b0;
        for (c2 = 0; c2 < 17; c2++) begin
            if (c2 == 10) func_code2 = 6'd29;
            #1;
            if (is_wwd2) begin
                wwd_pulses++;
                if (prev_wwd) back_to_back++;
            end
            prev_wwd = is_wwd2;
            if (c2 >= 2 && c2 <= 10 && (c2 % 2) == 0)
                chk("wrap_seq", 32'(num_inst2), seq[c2 / 2 - 1]);
            @(negedge clk);
        end
        chk("wrap_wwd_pulses", wwd_pulses, 5);
        chk("wrap_wwd_single", back_to_back, 0);
        chk("wrap_final", 32'(num_inst2), 1);
        chk("wrap_halted", 32'(halted2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
